// File: rtl/postfix_evaluator.sv
// ----------------------------------------------------------------------------
// postfix_evaluator
//   Evaluates a packed postfix token array (as produced by the infix-to-postfix
//   converter) on an internal operand stack, one token per clock, and returns a
//   signed W-bit result with done/error status.
//
//   Token encoding: postfix[0][i] = value, postfix[1][i] = flag
//   (zero = operand, nonzero = operator; '+'=43, '-'=45, '*'=42).
//   All arithmetic wraps modulo 2^W.
//
// Ports
//   CLK       in   clock, all state on rising edge
//   RST       in   asynchronous active-high reset (aborts any job, no done)
//   start     in   begin evaluation; accepted only when idle and not in the done cycle
//   len       in   number of valid tokens (slots 0..len-1)
//   postfix   in   [1:0][N-1:0][W-1:0] token array, captured on accepted start
//   busy      out  high while a job is in progress
//   done      out  one-cycle pulse when a job finishes (ok or error)
//   error     out  valid with done; held until next accepted start
//   err_code  out  0 none, 1 underflow, 2 bad op/overflow, 3 bad final depth/empty
//   result    out  final stack value; updated only by error-free jobs, held after
// ----------------------------------------------------------------------------
module postfix_evaluator #(
    parameter int N     = 13,
    parameter int W     = 16,
    parameter int DEPTH = 13
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic [$clog2(N+1)-1:0]      len,
    input  logic [1:0][N-1:0][W-1:0]    postfix,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  err_code,
    output logic [W-1:0]                result
);

    localparam int LW  = $clog2(N+1);
    localparam int SPW = $clog2(DEPTH+1);

    localparam logic [LW-1:0]  LEN_MAX = LW'(N);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [W-1:0]   OP_ADD  = W'(43);
    localparam logic [W-1:0]   OP_SUB  = W'(45);
    localparam logic [W-1:0]   OP_MUL  = W'(42);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // captured job
    logic [N-1:0][W-1:0]     val_r;
    logic [N-1:0]            opf_r;
    logic [LW-1:0]           len_r;
    logic [LW-1:0]           idx;

    // operand stack; sp counts occupied entries, top is stk[sp-1]
    logic [DEPTH-1:0][W-1:0] stk;
    logic [SPW-1:0]          sp;

    // token decode / ALU
    logic                    accept;
    logic                    last_tok;
    logic [W-1:0]            tok_val;
    logic                    tok_op;
    logic [1:0]              tok_err;
    logic [SPW-1:0]          ia, ib;
    logic [W-1:0]            opa, opb, alu;

    always_comb begin
        // The done cycle sits in IDLE; refusing start there makes a start
        // held through the done cycle land one cycle later.
        accept   = (state == S_IDLE) && start && !done;
        tok_val  = val_r[idx];
        tok_op   = opf_r[idx];
        last_tok = (idx == len_r - LW'(1));

        // Operand indices are clamped so an underflowing operator never reads
        // outside the stack; the result is discarded in that case anyway.
        ib  = (int'(sp) >= 1) ? SPW'(int'(sp) - 1) : '0;
        ia  = (int'(sp) >= 2) ? SPW'(int'(sp) - 2) : '0;
        opa = stk[ia];
        opb = stk[ib];

        case (tok_val)
            OP_ADD:  alu = opa + opb;
            OP_SUB:  alu = opa - opb;
            default: alu = opa * opb;   // low W bits of the product
        endcase

        // Underflow takes priority over an unknown operator code.
        tok_err = 2'd0;
        if (tok_op) begin
            if (int'(sp) < 2)
                tok_err = 2'd1;
            else if (!(tok_val == OP_ADD || tok_val == OP_SUB || tok_val == OP_MUL))
                tok_err = 2'd2;
        end else if (sp == SP_FULL) begin
            tok_err = 2'd2;
        end

        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (len == '0 || len > LEN_MAX) ? S_FINISH : S_RUN;
            end
            S_RUN: begin
                if (tok_err != 2'd0 || last_tok)
                    state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val_r    <= '0;
            opf_r    <= '0;
            len_r    <= '0;
            idx      <= '0;
            stk      <= '0;
            sp       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        val_r <= postfix[0];
                        for (int i = 0; i < N; i++)
                            opf_r[i] <= |postfix[1][i];
                        len_r    <= len;
                        idx      <= '0;
                        sp       <= '0;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    idx <= idx + LW'(1);
                    if (tok_err != 2'd0) begin
                        // first error wins; FSM leaves RUN this cycle
                        error    <= 1'b1;
                        err_code <= tok_err;
                    end else if (tok_op) begin
                        stk[ia] <= alu;
                        sp      <= sp - SPW'(1);
                    end else begin
                        stk[sp] <= tok_val;
                        sp      <= sp + SPW'(1);
                    end
                end
                S_FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (!error) begin
                        if (sp != SPW'(1)) begin
                            error    <= 1'b1;
                            err_code <= 2'd3;
                        end else begin
                            result <= stk[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_postfix_evaluator.sv
// ----------------------------------------------------------------------------
// tb_postfix_evaluator
//   Directed jobs with hand-computed expectations plus random jobs checked
//   against a queue-based stack model. One compare process checks done/busy
//   every cycle of a job and error/err_code/result at the done cycle.
//   The stack is made shallower than the slot count so overflow is reachable.
// ----------------------------------------------------------------------------
module tb_postfix_evaluator;

    localparam int N     = 13;
    localparam int W     = 16;
    localparam int DEPTH = 6;
    localparam int LW    = $clog2(N+1);

    logic                     CLK = 1'b0;
    logic                     RST = 1'b0;
    logic                     start = 1'b0;
    logic [LW-1:0]            len = '0;
    logic [1:0][N-1:0][W-1:0] postfix = '0;
    logic                     busy, done, error;
    logic [1:0]               err_code;
    logic [W-1:0]             result;

    always #5 CLK = ~CLK;

    postfix_evaluator #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .len      (len),
        .postfix  (postfix),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .result   (result)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- token building ----------------
    logic [1:0][N-1:0][W-1:0] pf;
    int                       ntok;

    task automatic clr();
        pf   = '0;
        ntok = 0;
    endtask

    task automatic num(input int v);
        if (ntok < N) begin
            pf[0][ntok] = W'(v);
            pf[1][ntok] = '0;
        end
        ntok++;
    endtask

    task automatic op(input int c);
        if (ntok < N) begin
            pf[0][ntok] = W'(c);
            pf[1][ntok] = W'(1);
        end
        ntok++;
    endtask

    // ---------------- reference model ----------------
    // edges = number of clock edges after the start edge until done is high.
    function automatic void model(input logic [1:0][N-1:0][W-1:0] p, input int l,
                                  output int code, output logic [W-1:0] res,
                                  output int edges);
        logic [W-1:0] st[$];
        logic [W-1:0] a, b, v, t;
        code = 0;
        res  = '0;
        if (l == 0 || l > N) begin
            code  = 3;
            edges = 1;
            return;
        end
        for (int i = 0; i < l; i++) begin
            v = p[0][i];
            if (p[1][i] != '0) begin
                if (st.size() < 2)
                    code = 1;
                else if (v != 42 && v != 43 && v != 45)
                    code = 2;
                else begin
                    b = st.pop_back();
                    a = st.pop_back();
                    if (v == 43)      t = a + b;
                    else if (v == 45) t = a - b;
                    else              t = a * b;
                    st.push_back(t);
                end
            end else if (st.size() >= DEPTH) begin
                code = 2;
            end else begin
                st.push_back(v);
            end
            if (code != 0) begin
                edges = i + 2;
                return;
            end
        end
        edges = l + 1;
        if (st.size() != 1) code = 3;
        else                res  = st[0];
    endfunction

    // ---------------- compare process ----------------
    int           exp_code, exp_edges, edge_cnt;
    logic [W-1:0] exp_res;
    logic [W-1:0] last_res = '0;
    bit           job_active = 0;
    bit           job_done   = 0;

    always @(negedge CLK) begin
        if (job_active) begin
            chk("done_timing", 32'(done), 32'(edge_cnt == exp_edges));
            chk("busy",        32'(busy), 32'(edge_cnt <  exp_edges));
            if (edge_cnt == exp_edges) begin
                chk("error",    32'(error),    32'(exp_code != 0));
                chk("err_code", 32'(err_code), 32'(exp_code));
                chk("result",   32'(result),   32'((exp_code == 0) ? exp_res : last_res));
                if (exp_code == 0) last_res = exp_res;
                job_active = 0;
                job_done   = 1;
            end
            edge_cnt++;
        end
    end

    // Runs one job from pf. Without 'early', start is raised just after the
    // next rising edge (back-to-back when called right after a done). With
    // 'early', start is raised in the current (done) cycle and held, so the
    // first edge must be ignored. 'repulse' re-pulses start mid-job.
    task automatic run_job(input int l, input bit early, input bit repulse);
        int t;
        model(pf, l, exp_code, exp_res, exp_edges);
        if (!early) begin
            @(posedge CLK);
            #1;
        end
        postfix = pf;
        len     = LW'(l);
        start   = 1'b1;
        if (early) @(posedge CLK);
        @(posedge CLK);
        #1;
        start      = 1'b0;
        postfix    = ~pf;       // captured copy must be unaffected
        len        = ~LW'(l);
        edge_cnt   = 0;
        job_done   = 0;
        job_active = 1;
        if (repulse && exp_edges >= 3) begin
            @(posedge CLK); #1 start = 1'b1;
            @(posedge CLK); #1 start = 1'b0;
        end
        t = 0;
        while (!job_done && t < 60) begin
            @(negedge CLK);
            #1;
            t++;
        end
        if (!job_done) begin
            chk("job_timeout", 32'(job_done), 32'd1);
            job_active = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #1 RST = 1'b1;
        #2;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_result",   32'(result),   32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // T1: 3 4 + 2 *  -> 14, done after edge 6
        clr(); num(3); num(4); op(43); num(2); op(42);
        run_job(5, 0, 0);
        chk("T1_model_edges", 32'(exp_edges), 32'd6);
        chk("T1_lit_result",  32'(result),    32'd14);

        // T2: -4 5 -  -> -9
        clr(); num(-4); num(5); op(45);
        run_job(3, 0, 0);
        chk("T2_lit_result", 32'(result), 32'h0000_FFF7);

        // T3: wrap on add and multiply
        clr(); num(16'h7FFF); num(1); op(43);
        run_job(3, 0, 0);
        chk("T3a_lit_result", 32'(result), 32'h0000_8000);
        clr(); num(16'h0100); num(16'h0100); op(42);
        run_job(3, 0, 0);
        chk("T3b_lit_result", 32'(result), 32'h0000_0000);

        // T4: error cases
        clr(); num(5); op(43);
        run_job(2, 0, 0);
        chk("T4_underflow_code", 32'(err_code), 32'd1);
        chk("T4_underflow_edges", 32'(exp_edges), 32'd3);
        clr(); num(1); num(2);
        run_job(2, 0, 0);
        chk("T4_depth_code", 32'(err_code), 32'd3);
        clr(); num(8); num(2); op(47);
        run_job(3, 0, 0);
        chk("T4_badop_code", 32'(err_code), 32'd2);
        clr(); for (int i = 0; i < DEPTH + 1; i++) num(i + 1);
        run_job(DEPTH + 1, 0, 0);
        chk("T4_overflow_code",  32'(err_code),  32'd2);
        chk("T4_overflow_edges", 32'(exp_edges), 32'(DEPTH + 2));
        clr(); num(7);
        run_job(0, 0, 0);
        chk("T4_len0_code",  32'(err_code), 32'd3);
        chk("T4_len0_edges", 32'(exp_edges), 32'd1);
        run_job(N + 2, 0, 0);
        chk("T4_lenbig_code", 32'(err_code), 32'd3);
        chk("T4_held_result", 32'(result),   32'd0);

        // T5: start re-pulsed mid-run, then start held through the done cycle
        clr(); num(3); num(4); op(43); num(2); op(42);
        run_job(5, 0, 1);
        chk("T5_repulse_result", 32'(result), 32'd14);
        clr(); num(-4); num(5); op(45);
        run_job(3, 1, 0);
        chk("T5_early_result", 32'(result), 32'h0000_FFF7);

        // T5: reset mid-run aborts with no done pulse
        clr(); num(3); num(4); op(43); num(2); op(42);
        @(posedge CLK); #1;
        postfix = pf; len = LW'(5); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(posedge CLK); @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("midrst_busy",     32'(busy),     32'd0);
        chk("midrst_done",     32'(done),     32'd0);
        chk("midrst_error",    32'(error),    32'd0);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        chk("midrst_result",   32'(result),   32'd0);
        last_res = '0;
        @(posedge CLK); #1 RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        run_job(5, 0, 0);
        chk("midrst_rerun_result", 32'(result), 32'd14);

        // T6: random jobs, back-to-back, sometimes start held through done
        for (int j = 0; j < 1000; j++) begin
            int l, d, r;
            clr();
            r = $urandom_range(0, 99);
            if (r < 3)      l = 0;
            else if (r < 6) l = N + $urandom_range(1, 2);
            else            l = $urandom_range(1, N);
            d = 0;
            for (int k = 0; k < l && k < N; k++) begin
                r = $urandom_range(0, 99);
                if (r < 3)
                    op(47);
                else if (r < 6)
                    op(43);
                else if (d >= 2 && r < 55) begin
                    case ($urandom_range(0, 2))
                        0:       op(43);
                        1:       op(45);
                        default: op(42);
                    endcase
                    d--;
                end else begin
                    if ($urandom_range(0, 1) == 0) num($urandom_range(0, 20));
                    else                           num(int'($urandom_range(0, 65535)));
                    d++;
                end
            end
            run_job(l, $urandom_range(0, 3) == 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
